fft32_frame_sched: RTL
======================

Name: fft32_frame_sched

Overview:
Frame scheduler in front of the serial FFT32 core. It accepts a stream of complex SFP samples on a valid/ready handshake and assembles them into 32-sample frames in a two-bank ping-pong buffer. It issues the core START pulse and feeds each frame on consecutive cycles. It tracks frames in flight through the fixed core latency and tags the core output stream with valid, bin index, last and frame count.

Parameters:
NB, 16, width of one SFP real or imaginary word; matches the shared `nb` definition.
N, 32, samples per frame; power of two.
LATENCY, 64, cycles from the core START cycle S to the first output sample on core_or/core_oi; must be at least 2.

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-low reset
flush  in  1  synchronous; discards buffered frames that have not started
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_re  in  NB  input real part
in_im  in  NB  input imaginary part
in_last  in  1  source marks the last sample of a frame; used for checking only
core_start  out  1  one-cycle START pulse to FFT32
core_dr  out  NB  real sample to the core
core_di  out  NB  imaginary sample to the core
core_or  in  NB  real output from the core
core_oi  in  NB  imaginary output from the core
out_valid  out  1  output sample valid
out_re  out  NB  registered core_or
out_im  out  NB  registered core_oi
out_index  out  log2(N)  output bin index
out_last  out  1  last sample of an output frame
out_frame  out  8  output frame count; wraps from 255 to 0
err_frame  out  1  sticky framing error

Behaviour:
- Reset (RST=0): core_start=0; core_dr=core_di=0; out_valid=out_last=0; out_re=out_im=0; out_index=0; out_frame=0; err_frame=0. Both banks EMPTY, write bank=A, issue FSM=IDLE, in-flight line cleared. in_ready=0 while RST=0 and 1 on the first cycle after release.
- Bank states are EMPTY, FILL, FULL and DRAIN. A sample is written when in_valid&in_ready. The write pointer counts 0..N-1. When sample N-1 is written, that bank goes FULL and the write bank toggles.
- in_ready=1 only when the current write bank is EMPTY or FILL.
- err_frame is set when in_last=1 on any write with pointer≠N-1, or in_last=0 with pointer=N-1. Framing always follows the count; in_last never shortens a frame.
- Issue FSM states are IDLE, START and FEED.
  - IDLE→START when the read bank is FULL. core_start=1 for that one cycle (cycle S) and the bank goes DRAIN.
  - START→FEED. During FEED, core_dr/core_di present samples 0..N-1 on cycles S+1..S+N, registered.
  - On the cycle sample N-1 is presented, the bank goes EMPTY and the read bank toggles. If the other bank is FULL, the next state is START, giving a back-to-back START period of N+1. Otherwise the next state is IDLE and core_dr/di hold their last value.
- A bank released on the last FEED cycle is writable on the next cycle. Writing it in that same cycle is not allowed.
- In-flight tracking: core_start is fed into a LATENCY-deep shift line. When the delayed pulse emerges at cycle S+LATENCY, the output counter starts.
  - out_valid=1 on cycles S+LATENCY+1..S+LATENCY+N, with out_re/out_im = core_or/core_oi from the previous cycle.
  - out_index counts 0..N-1. out_last=1 when out_index=N-1. out_frame increments after out_last.
  - Overlapping output windows cannot occur because the START spacing is at least N+1.
- flush: FULL and FILL banks become EMPTY, the write pointer is cleared, and the write bank is set to the bank not in DRAIN (A if none). An active FEED completes its frame because the core cannot abort. The in-flight line and output counter are unaffected. flush takes priority over a simultaneous input write, which is dropped; in_ready=0 during the flush cycle.
- Reset mid-operation aborts everything immediately. The core must be reset by the same RST.

Optional Feature:
FFT_BITREV_EN: when defined, out_index = bit-reverse of the output counter, giving natural-order bin numbers for a core that emits in bit-reversed order. When undefined, out_index equals the output counter in 0..N-1 order. Timing is identical in both cases.

Decomposition:
- Shared header/package: NB (via `nb`), N, LOGN=$clog2(N), bank state encodings (EMPTY/FILL/FULL/DRAIN), issue FSM encodings (IDLE/START/FEED), and a bitrev function.
- Sub-module fft_frame_bank: one N×2NB register bank with its write pointer and state, instantiated twice.
- The scheduler top holds the issue FSM, the START delay line and the output tagger.

Test Plan:
1. Reset release, one frame with in_re=k, in_im=k+32 for k=0..31 and in_valid held high → core_start one cycle after the 32nd write. core_dr=0..31 on S+1..S+32. out_valid rises at S+65, out_last at S+96, out_frame 0→1.
2. Three frames streamed without gaps → START spacing exactly 33 cycles. in_ready drops when both banks are occupied and reasserts the cycle after each final FEED sample. out_frame reaches 3.
3. in_last at sample 15 of a frame → err_frame=1 and stays 1. Framing is unchanged: START occurs after the 32nd sample.
4. flush at sample 20 of frame 2 while frame 1 is in FEED → frame 1 is fully fed. No START is issued for frame 2. The next 32 samples form a new frame that is issued normally.
5. RST pulled low during FEED sample 10 → all outputs return to reset values at once. in_ready=1 on the first cycle after release. No stale out_valid appears afterwards.
6. With FFT_BITREV_EN defined → the out_index sequence is 0,16,8,24,4,… over 32 outputs. Without it → 0,1,2,…,31.

Source files
------------

// File: rtl/fft32_frame_sched_pkg.sv
// rtl/fft32_frame_sched_pkg.sv - shared widths, state encodings and bit-reverse helper for the FFT32 frame scheduler
package fft32_frame_sched_pkg;

`ifndef FFT_NB
`define FFT_NB 16
`endif

  localparam int NB          = `FFT_NB;
  localparam int N           = 32;
  localparam int LOGN        = $clog2(N);
  localparam int DEF_LATENCY = 64;

  // Life cycle of one ping-pong bank
  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_FULL  = 2'd2,
    BANK_DRAIN = 2'd3
  } bank_state_t;

  // Issue FSM that starts the core and feeds it one frame
  typedef enum logic [1:0] {
    ISS_IDLE  = 2'd0,
    ISS_START = 2'd1,
    ISS_FEED  = 2'd2
  } issue_state_t;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = v[LOGN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// rtl/fft_frame_bank.sv - one N-sample complex frame bank with write pointer and bank state
module fft_frame_bank
  import fft32_frame_sched_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            wr_en,
  input  logic [NB-1:0]   wr_re,
  input  logic [NB-1:0]   wr_im,
  input  logic            clear,
  input  logic            start,
  input  logic            drain_done,
  input  logic [LOGN-1:0] rd_addr,
  output bank_state_t     state,
  output logic [LOGN-1:0] wr_ptr,
  output logic [NB-1:0]   rd_re,
  output logic [NB-1:0]   rd_im
);

  logic [NB-1:0] mem_re [N];
  logic [NB-1:0] mem_im [N];

  // Sample storage; contents are don't-care until written, so no reset
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_re[wr_ptr] <= wr_re;
      mem_im[wr_ptr] <= wr_im;
    end
  end

  assign rd_re = mem_re[rd_addr];
  assign rd_im = mem_im[rd_addr];

  // Bank state and write pointer; release and start never coincide with clear or write on the same bank
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= BANK_EMPTY;
      wr_ptr <= '0;
    end else begin
      if (drain_done) begin
        state <= BANK_EMPTY;
      end else if (start) begin
        state <= BANK_DRAIN;
      end else if (clear) begin
        if (state == BANK_FILL || state == BANK_FULL) state <= BANK_EMPTY;
      end else if (wr_en) begin
        state <= (wr_ptr == LOGN'(N-1)) ? BANK_FULL : BANK_FILL;
      end

      if (clear)      wr_ptr <= '0;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fft32_frame_sched.sv
// rtl/fft32_frame_sched.sv - ping-pong frame scheduler and output tagger for the serial FFT32 core; FFT_BITREV_EN selects bit-reversed out_index
module fft32_frame_sched
  import fft32_frame_sched_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
)(
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NB-1:0]   in_re,
  input  logic [NB-1:0]   in_im,
  input  logic            in_last,
  output logic            core_start,
  output logic [NB-1:0]   core_dr,
  output logic [NB-1:0]   core_di,
  input  logic [NB-1:0]   core_or,
  input  logic [NB-1:0]   core_oi,
  output logic            out_valid,
  output logic [NB-1:0]   out_re,
  output logic [NB-1:0]   out_im,
  output logic [LOGN-1:0] out_index,
  output logic            out_last,
  output logic [7:0]      out_frame,
  output logic            err_frame
);

  bank_state_t     st_a, st_b, wb_state, rd_state, other_state;
  logic [LOGN-1:0] ptr_a, ptr_b, wr_ptr, rd_addr, feed_cnt, ocnt;
  logic [NB-1:0]   rd_re_a, rd_im_a, rd_re_b, rd_im_b, rd_re, rd_im;
  logic            wr_sel, rd_sel, we, wr_done;
  logic            issue, issue_sel, feed_last;
  logic            has_drain, drain_sel, emerge;
  logic [LATENCY-1:0] dly;
  issue_state_t    iss_q, iss_d;

  assign wb_state    = wr_sel ? st_b : st_a;
  assign rd_state    = rd_sel ? st_b : st_a;
  assign other_state = rd_sel ? st_a : st_b;
  assign wr_ptr      = wr_sel ? ptr_b : ptr_a;
  assign rd_re       = rd_sel ? rd_re_b : rd_re_a;
  assign rd_im       = rd_sel ? rd_im_b : rd_im_a;

  assign in_ready = RST && !flush && (wb_state == BANK_EMPTY || wb_state == BANK_FILL);
  assign we       = in_valid && in_ready;
  assign wr_done  = we && (wr_ptr == LOGN'(N-1));
  assign rd_addr  = (iss_q == ISS_FEED) ? feed_cnt + 1'b1 : '0;

  assign has_drain = (st_a == BANK_DRAIN) || (st_b == BANK_DRAIN);
  assign drain_sel = (st_a != BANK_DRAIN);

  fft_frame_bank u_bank_a (
    .CLK        (CLK),
    .RST        (RST),
    .wr_en      (we && !wr_sel),
    .wr_re      (in_re),
    .wr_im      (in_im),
    .clear      (flush),
    .start      (issue && !issue_sel),
    .drain_done (feed_last && !rd_sel),
    .rd_addr    (rd_addr),
    .state      (st_a),
    .wr_ptr     (ptr_a),
    .rd_re      (rd_re_a),
    .rd_im      (rd_im_a)
  );

  fft_frame_bank u_bank_b (
    .CLK        (CLK),
    .RST        (RST),
    .wr_en      (we && wr_sel),
    .wr_re      (in_re),
    .wr_im      (in_im),
    .clear      (flush),
    .start      (issue && issue_sel),
    .drain_done (feed_last && rd_sel),
    .rd_addr    (rd_addr),
    .state      (st_b),
    .wr_ptr     (ptr_b),
    .rd_re      (rd_re_b),
    .rd_im      (rd_im_b)
  );

  // Bank selection: toggle on frame boundaries; flush re-aims both selects around any draining bank
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else if (flush) begin
      wr_sel <= has_drain ? !drain_sel : 1'b0;
      rd_sel <= has_drain ? (feed_last ? !drain_sel : drain_sel) : 1'b0;
    end else begin
      if (wr_done)   wr_sel <= !wr_sel;
      if (feed_last) rd_sel <= !rd_sel;
    end
  end

  // Sticky framing check: in_last must coincide exactly with the final sample of a frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_frame <= 1'b0;
    end else if (we && (in_last != (wr_ptr == LOGN'(N-1)))) begin
      err_frame <= 1'b1;
    end
  end

  // Issue FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) iss_q <= ISS_IDLE;
    else      iss_q <= iss_d;
  end

  // Issue FSM next state; a flush cycle never starts a frame since that frame is being discarded
  always_comb begin
    iss_d     = iss_q;
    issue     = 1'b0;
    issue_sel = rd_sel;
    feed_last = 1'b0;
    case (iss_q)
      ISS_IDLE: begin
        if (rd_state == BANK_FULL && !flush) begin
          iss_d = ISS_START;
          issue = 1'b1;
        end
      end
      ISS_START: iss_d = ISS_FEED;
      ISS_FEED: begin
        if (feed_cnt == LOGN'(N-1)) begin
          feed_last = 1'b1;
          if (other_state == BANK_FULL && !flush) begin
            iss_d     = ISS_START;
            issue     = 1'b1;
            issue_sel = !rd_sel;
          end else begin
            iss_d = ISS_IDLE;
          end
        end
      end
      default: iss_d = ISS_IDLE;
    endcase
  end

  assign core_start = (iss_q == ISS_START);

  // Registered feed path: sample 0 loads at the end of START, sample k+1 while k is presented
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      core_dr  <= '0;
      core_di  <= '0;
      feed_cnt <= '0;
    end else if (iss_q == ISS_START) begin
      core_dr  <= rd_re;
      core_di  <= rd_im;
      feed_cnt <= '0;
    end else if (iss_q == ISS_FEED && !feed_last) begin
      core_dr  <= rd_re;
      core_di  <= rd_im;
      feed_cnt <= feed_cnt + 1'b1;
    end
  end

  // START delay line matching the core latency
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) dly <= '0;
    else      dly <= {dly[LATENCY-2:0], core_start};
  end

  assign emerge = dly[LATENCY-1];

  // Output tagger: one N-sample window per emerged START
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      ocnt      <= '0;
      out_frame <= '0;
    end else begin
      out_re <= core_or;
      out_im <= core_oi;
      if (emerge) begin
        out_valid <= 1'b1;
        ocnt      <= '0;
      end else if (out_valid) begin
        ocnt <= ocnt + 1'b1;
        if (ocnt == LOGN'(N-1)) begin
          out_valid <= 1'b0;
          out_frame <= out_frame + 1'b1;
        end
      end
    end
  end

  assign out_last = out_valid && (ocnt == LOGN'(N-1));

`ifdef FFT_BITREV_EN
  assign out_index = bitrev(ocnt);
`else
  assign out_index = ocnt;
`endif

endmodule
